// File: rtl/manual_drive_ctrl.sv
// Manual-drive mode sequencer: power/drive state machine, odometer tick and clear generation.
// Pedal/switch inputs are resynchronised here; every output comes straight from a flop.
module manual_drive_ctrl #(
    parameter int CLK_HZ       = 100_000_000,
    parameter int PWR_HOLD_CYC = CLK_HZ,
    parameter int TICK_CYC     = CLK_HZ / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       power_on_btn,
    input  logic       power_off_btn,
    input  logic       throttle,
    input  logic       clutch,
    input  logic       brake,
    input  logic       reverse,
    output logic [3:0] state,
    output logic       power_now,
    output logic       odo_tick,
    output logic       odo_clear,
    output logic       reverse_lat
);

    localparam int HOLD_W = $clog2(PWR_HOLD_CYC);
    localparam int TICK_W = $clog2(TICK_CYC);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(PWR_HOLD_CYC - 1);
    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_CYC - 1);

    typedef enum logic [3:0] {
        ST_OFF       = 4'b0001,
        ST_NOT_START = 4'b0010,
        ST_STARTING  = 4'b1000,
        ST_MOVING    = 4'b0100
    } state_t;

    state_t            state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              hold_done_q, hold_done_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              power_now_q, power_now_d;
    logic              odo_tick_q, odo_tick_d;
    logic              odo_clear_q, odo_clear_d;
    logic              rev_lat_q, rev_lat_d;
    logic [5:0]        meta_q, sync_q;

    logic pon_s, poff_s, thr_s, clu_s, brk_s, rev_s;
    logic power_up_s;

    assign {pon_s, poff_s, thr_s, clu_s, brk_s, rev_s} = sync_q;

    // Two-stage synchroniser for the six level inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 6'b000000;
            sync_q <= 6'b000000;
        end else begin
            meta_q <= {power_on_btn, power_off_btn, throttle, clutch, brake, reverse};
            sync_q <= meta_q;
        end
    end

    // Power-on hold qualification: the counter saturates and hold_done blocks a
    // second power-up until the button has been released.
    always_comb begin
        hold_cnt_d  = hold_cnt_q;
        hold_done_d = hold_done_q;
        power_up_s  = 1'b0;
        if (pon_s) begin
            if (hold_cnt_q != HOLD_MAX) begin
                hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end else begin
                hold_cnt_d = hold_cnt_q;
            end
            if ((state_q == ST_OFF) && (hold_cnt_q == HOLD_MAX) && !hold_done_q) begin
                power_up_s  = 1'b1;
                hold_done_d = 1'b1;
            end else begin
                power_up_s  = 1'b0;
            end
        end else begin
            hold_cnt_d  = '0;
            hold_done_d = 1'b0;
        end
    end

    // Drive-state transitions; power-off dominates everywhere except OFF.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OFF: begin
                if (power_up_s) state_d = ST_NOT_START;
                else            state_d = ST_OFF;
            end
            ST_NOT_START: begin
                if (poff_s)                         state_d = ST_OFF;
                else if (thr_s && !clu_s)           state_d = ST_OFF;
                else if (thr_s && clu_s && !brk_s)  state_d = ST_STARTING;
                else                                state_d = ST_NOT_START;
            end
            ST_STARTING: begin
                if (poff_s)                         state_d = ST_OFF;
                else if (brk_s)                     state_d = ST_NOT_START;
                else if (thr_s && !clu_s)           state_d = ST_MOVING;
                else                                state_d = ST_STARTING;
            end
            ST_MOVING: begin
                if (poff_s)                         state_d = ST_OFF;
                else if ((rev_s != rev_lat_q) && !clu_s) state_d = ST_OFF;
                else if (brk_s)                     state_d = ST_NOT_START;
                else if (clu_s || !thr_s)           state_d = ST_STARTING;
                else                                state_d = ST_MOVING;
            end
            default: state_d = ST_OFF;
        endcase
    end

    // Gear latch, mileage interval counter and registered output values.
    always_comb begin
        rev_lat_d   = rev_lat_q;
        tick_cnt_d  = '0;
        if (clu_s && ((state_q == ST_NOT_START) || (state_q == ST_STARTING) ||
                      (state_q == ST_MOVING))) begin
            rev_lat_d = rev_s;
        end else begin
            rev_lat_d = rev_lat_q;
        end
        // Leaving MOVING discards the partial interval.
        if ((state_q == ST_MOVING) && (state_d == ST_MOVING)) begin
            if (tick_cnt_q == TICK_MAX) tick_cnt_d = '0;
            else                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
        end else begin
            tick_cnt_d = '0;
        end
        odo_tick_d  = (state_q == ST_MOVING) && (tick_cnt_q == TICK_MAX);
        odo_clear_d = power_up_s;
        power_now_d = (state_d != ST_OFF);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_OFF;
            hold_cnt_q  <= '0;
            hold_done_q <= 1'b0;
            tick_cnt_q  <= '0;
            power_now_q <= 1'b0;
            odo_tick_q  <= 1'b0;
            odo_clear_q <= 1'b0;
            rev_lat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            hold_done_q <= hold_done_d;
            tick_cnt_q  <= tick_cnt_d;
            power_now_q <= power_now_d;
            odo_tick_q  <= odo_tick_d;
            odo_clear_q <= odo_clear_d;
            rev_lat_q   <= rev_lat_d;
        end
    end

    assign state       = state_q;
    assign power_now   = power_now_q;
    assign odo_tick    = odo_tick_q;
    assign odo_clear   = odo_clear_q;
    assign reverse_lat = rev_lat_q;

endmodule

// File: tb/tb_manual_drive_ctrl.sv
// Scoreboard bench: stimulus queues each expected output change with the cycle it must
// appear on; a monitor pops and compares whenever the sampled outputs change.
module tb_manual_drive_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       pon, poff, thr, clu, brk, rev;
    logic [3:0] state;
    logic       power_now, odo_tick, odo_clear, reverse_lat;

    int cyc   = 0;
    int n_cmp = 0;
    int n_err = 0;
    int c;

    logic [7:0] exp_val_q[$];
    int         exp_cyc_q[$];
    string      exp_name_q[$];

    manual_drive_ctrl #(.PWR_HOLD_CYC(10), .TICK_CYC(4)) dut (
        .clk(clk), .rst(rst),
        .power_on_btn(pon), .power_off_btn(poff),
        .throttle(thr), .clutch(clu), .brake(brk), .reverse(rev),
        .state(state), .power_now(power_now), .odo_tick(odo_tick),
        .odo_clear(odo_clear), .reverse_lat(reverse_lat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_ev(input string nm, input logic [3:0] st, input logic pn,
                             input logic tk, input logic cl, input logic lt, input int at);
        exp_val_q.push_back({st, pn, tk, cl, lt});
        exp_cyc_q.push_back(at);
        exp_name_q.push_back(nm);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every change of {state,power_now,odo_tick,odo_clear,reverse_lat} is an event.
    initial begin
        logic [7:0] obs, prev_obs, ev;
        int ec;
        string nm;
        prev_obs = 8'hxx;
        forever begin
            @(negedge clk);
            obs = {state, power_now, odo_tick, odo_clear, reverse_lat};
            if (obs !== prev_obs) begin
                n_cmp++;
                if (exp_val_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_event: got %b at cycle %0d, required no change",
                             obs, cyc);
                end else begin
                    ev = exp_val_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    nm = exp_name_q.pop_front();
                    if ((obs !== ev) || ((ec >= 0) && (cyc != ec))) begin
                        n_err++;
                        $display("FAIL %s: got %b at cycle %0d, required %b at cycle %0d",
                                 nm, obs, cyc, ev, ec);
                    end
                end
                prev_obs = obs;
            end
        end
    end

    initial begin
        int budget;
        rst = 1'b1; pon = 1'b0; poff = 1'b0; thr = 1'b0; clu = 1'b0; brk = 1'b0; rev = 1'b0;
        expect_ev("reset_state", 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        step(3); rst = 1'b0;
        step(3);

        // 9-cycle hold must not power up
        pon = 1'b1; step(9); pon = 1'b0; step(15);

        // 10-cycle hold with power_off also held: power-up proceeds
        c = cyc; pon = 1'b1; poff = 1'b1;
        expect_ev("power_up",       4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, c + 12);
        expect_ev("clear_one_shot", 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, c + 13);
        step(10); pon = 1'b0; poff = 1'b0; step(6);

        // start, drive 13 cycles, three ticks, brake out
        c = cyc; thr = 1'b1; clu = 1'b1;
        expect_ev("to_starting", 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0, c + 3);
        step(5);
        c = cyc; clu = 1'b0;
        expect_ev("to_moving",   4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, c + 3);
        expect_ev("tick1_rise",  4'b0100, 1'b1, 1'b1, 1'b0, 1'b0, c + 7);
        expect_ev("tick1_fall",  4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, c + 8);
        expect_ev("tick2_rise",  4'b0100, 1'b1, 1'b1, 1'b0, 1'b0, c + 11);
        expect_ev("tick2_fall",  4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, c + 12);
        expect_ev("tick3_rise",  4'b0100, 1'b1, 1'b1, 1'b0, 1'b0, c + 15);
        expect_ev("brake_exit",  4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, c + 16);
        step(13); brk = 1'b1; thr = 1'b0; step(6);
        brk = 1'b0; step(3);

        // stall
        c = cyc; thr = 1'b1;
        expect_ev("stall", 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, c + 3);
        step(5); thr = 1'b0; step(3);

        // power up again, gear crash with clutch released
        c = cyc; pon = 1'b1;
        expect_ev("power_up2",       4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, c + 12);
        expect_ev("clear_one_shot2", 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, c + 13);
        step(10); pon = 1'b0; step(6);
        c = cyc; thr = 1'b1; clu = 1'b1;
        expect_ev("to_starting2", 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0, c + 3);
        step(5);
        c = cyc; clu = 1'b0;
        expect_ev("to_moving2",  4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, c + 3);
        expect_ev("gear_crash",  4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, c + 6);
        step(3); rev = 1'b1; step(6);
        thr = 1'b0; rev = 1'b0; step(3);

        // power up, gear change with clutch held latches reverse
        c = cyc; pon = 1'b1;
        expect_ev("power_up3",       4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, c + 12);
        expect_ev("clear_one_shot3", 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, c + 13);
        step(10); pon = 1'b0; step(6);
        c = cyc; thr = 1'b1; clu = 1'b1;
        expect_ev("to_starting3", 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0, c + 3);
        step(5);
        c = cyc; clu = 1'b0;
        expect_ev("to_moving3",        4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, c + 3);
        expect_ev("clutch_gear_change", 4'b1000, 1'b1, 1'b0, 1'b0, 1'b1, c + 6);
        step(3); rev = 1'b1; clu = 1'b1; step(6);

        // short MOVING interval then brake: no tick
        c = cyc; clu = 1'b0;
        expect_ev("to_moving_rev",    4'b0100, 1'b1, 1'b0, 1'b0, 1'b1, c + 3);
        expect_ev("brake_exit_short", 4'b0010, 1'b1, 1'b0, 1'b0, 1'b1, c + 6);
        step(3); brk = 1'b1; thr = 1'b0; step(6);
        brk = 1'b0; step(2);

        // re-enter MOVING: tick interval restarts from zero
        c = cyc; thr = 1'b1; clu = 1'b1;
        expect_ev("to_starting4", 4'b1000, 1'b1, 1'b0, 1'b0, 1'b1, c + 3);
        step(5);
        c = cyc; clu = 1'b0;
        expect_ev("to_moving4",         4'b0100, 1'b1, 1'b0, 1'b0, 1'b1, c + 3);
        expect_ev("reentry_first_tick", 4'b0100, 1'b1, 1'b1, 1'b0, 1'b1, c + 7);
        expect_ev("reentry_tick_fall",  4'b0100, 1'b1, 1'b0, 1'b0, 1'b1, c + 8);
        expect_ev("reentry_tick2",      4'b0100, 1'b1, 1'b1, 1'b0, 1'b1, c + 11);
        expect_ev("async_reset",        4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, c + 12);
        step(11);

        // async reset between edges while odo_tick is high
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({state, power_now, odo_tick, odo_clear, reverse_lat} !== 8'b0001_0000) begin
            n_err++;
            $display("FAIL async_reset_immediate: got %b, required %b",
                     {state, power_now, odo_tick, odo_clear, reverse_lat}, 8'b0001_0000);
        end
        step(3); rst = 1'b0; step(3);

        budget = 0;
        while ((exp_val_q.size() != 0) && (budget < 50)) begin
            step(1);
            budget++;
        end
        n_cmp++;
        if (exp_val_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending events, required 0",
                     exp_val_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
